jogo_sequencia_param: RTL and testbench

JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

---
 rtl/jogo_sequencia_param.sv | 171 +++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_param.sv
// Sequence memory game: player repeats one-hot symbols, growing by one each round.
// Latency: play edge at clock t -> compara at t+2 -> fim_* outputs after t+3.
// No backpressure: keys are sampled every cycle, and plays outside espera_jogada are ignored.
module jogo_sequencia_param #(
  parameter int N_CHAVES       = 4,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000,
  localparam int CW            = $clog2(N_JOGADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [N_CHAVES-1:0] leds,
  output logic [CW-1:0]       db_rodada,
  output logic [CW-1:0]       db_contagem,
  output logic [3:0]          db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0] ULTIMA    = CW'(N_JOGADAS - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA_JOGADA  = 4'h2,
    REGISTRA       = 4'h3,
    COMPARA        = 4'h4,
    PROXIMA_JOGADA = 4'h5,
    PROXIMA_RODADA = 4'h6,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  estado_t             estado;
  logic [N_CHAVES-1:0] chaves_ant;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       rodada;
  logic [CW-1:0]       contagem;
  logic                jogada;

  // Expected symbol at a sequence position: one-hot, bit (pos mod N_CHAVES).
  function automatic logic [N_CHAVES-1:0] simbolo(input logic [CW-1:0] pos);
    logic [N_CHAVES-1:0] s;
    s = '0;
    for (int k = 0; k < N_CHAVES; k++) begin
      s[k] = ((int'(pos) % N_CHAVES) == k);
    end
    return s;
  endfunction

  // A play is a release-to-press transition, so keys held on entry never count.
  assign jogada = (chaves != '0) && (chaves_ant == '0);

  assign db_estado   = estado;
  assign db_rodada   = rodada;
  assign db_contagem = contagem;

  // Previous key sample, refreshed every cycle regardless of state.
  always_ff @(posedge clock) begin
    if (reset) chaves_ant <= '0;
    else       chaves_ant <= chaves;
  end

  // Game FSM with registered Moore flags; flags default low and are re-asserted while in fim_*.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      timer    <= '0;
      rodada   <= '0;
      contagem <= '0;
      leds     <= '0;
      acertou  <= 1'b0;
      errou    <= 1'b0;
      timeout  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      acertou <= 1'b0;
      errou   <= 1'b0;
      timeout <= 1'b0;
      pronto  <= 1'b0;
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            estado   <= PREPARACAO;
            timer    <= '0;
            rodada   <= '0;
            contagem <= '0;
            leds     <= '0;
          end
        end
        PREPARACAO: begin
          timer    <= '0;
          rodada   <= '0;
          contagem <= '0;
          leds     <= '0;
          estado   <= ESPERA_JOGADA;
        end
        ESPERA_JOGADA: begin
          // A play in the expiry cycle still counts.
          if (jogada) begin
            leds   <= chaves;
            estado <= REGISTRA;
          end else if (timer == TIMER_MAX) begin
            estado  <= FIM_TIMEOUT;
            errou   <= 1'b1;
            timeout <= 1'b1;
            pronto  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REGISTRA: estado <= COMPARA;
        COMPARA: begin
          if (leds != simbolo(contagem)) begin
            estado <= FIM_ERRO;
            errou  <= 1'b1;
            pronto <= 1'b1;
          end else if (contagem != rodada) begin
            estado <= PROXIMA_JOGADA;
          end else if (rodada != ULTIMA) begin
            estado <= PROXIMA_RODADA;
          end else begin
            estado  <= FIM_ACERTO;
            acertou <= 1'b1;
            pronto  <= 1'b1;
          end
        end
        PROXIMA_JOGADA: begin
          contagem <= contagem + 1'b1;
          timer    <= '0;
          estado   <= ESPERA_JOGADA;
        end
        PROXIMA_RODADA: begin
          rodada   <= rodada + 1'b1;
          contagem <= '0;
          timer    <= '0;
          estado   <= ESPERA_JOGADA;
        end
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
          if (iniciar) begin
            estado   <= PREPARACAO;
            timer    <= '0;
            rodada   <= '0;
            contagem <= '0;
            leds     <= '0;
          end else begin
            acertou <= (estado == FIM_ACERTO);
            errou   <= (estado != FIM_ACERTO);
            timeout <= (estado == FIM_TIMEOUT);
            pronto  <= 1'b1;
          end
        end
        default: begin
          estado   <= INICIAL;
          timer    <= '0;
          rodada   <= '0;
          contagem <= '0;
          leds     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: directed scenarios followed by random games against an abstract model.
// Every check occurs one time unit after a rising edge; inputs change at that same point.
// Game pacing leaves at least four cycles between plays so that each press lands in espera_jogada.
module tb_jogo_sequencia_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] leds;
  logic [1:0] db_rodada, db_contagem;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;

  jogo_sequencia_param #(.N_CHAVES(4), .N_JOGADAS(4), .TIMEOUT_CICLOS(50)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .leds(leds), .db_rodada(db_rodada), .db_contagem(db_contagem), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit e_a, input bit e_e, input bit e_t, input bit e_p,
                           input logic [3:0] e_leds, input logic [1:0] e_rod, input logic [1:0] e_cont,
                           input logic [3:0] e_est);
    chk({tag, "/estado"},   32'(db_estado),   32'(e_est));
    chk({tag, "/acertou"},  32'(acertou),     32'(e_a));
    chk({tag, "/errou"},    32'(errou),       32'(e_e));
    chk({tag, "/timeout"},  32'(timeout),     32'(e_t));
    chk({tag, "/pronto"},   32'(pronto),      32'(e_p));
    chk({tag, "/leds"},     32'(leds),        32'(e_leds));
    chk({tag, "/rodada"},   32'(db_rodada),   32'(e_rod));
    chk({tag, "/contagem"}, 32'(db_contagem), 32'(e_cont));
  endtask

  // Pulse iniciar, then step through preparacao so the next press is seen in espera_jogada.
  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  task automatic play(input logic [3:0] v, input int hold, input int rel);
    chaves = v;
    repeat (hold) tick();
    chaves = 4'b0000;
    repeat (rel) tick();
  endtask

  // Reference model state for random games.
  int         fim;
  int         rf, cf;
  logic [3:0] last, sym, exp_sym, e_est;

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    chaves = 4'b0000;
    repeat (3) tick();
    check_out("reset", 0, 0, 0, 0, 4'h0, 2'd0, 2'd0, 4'h0);
    reset = 1'b0;
    tick();
    chk("idle_inicial", 32'(db_estado), 32'h0);

    // Winning game; the first play also checks state-by-state latency.
    start();
    chk("win_espera", 32'(db_estado), 32'h2);
    chaves = 4'b0001;
    tick();
    chk("lat_registra", 32'(db_estado), 32'h3);
    chaves = 4'b0000;
    tick();
    chk("lat_compara", 32'(db_estado), 32'h4);
    tick();
    chk("lat_prox_rodada", 32'(db_estado), 32'h6);
    tick();
    check_out("lat_back", 0, 0, 0, 0, 4'b0001, 2'd1, 2'd0, 4'h2);
    for (int r = 1; r < 4; r++) begin
      for (int c = 0; c <= r; c++) begin
        sym = 4'b0001 << c;
        play(sym, 2, 3);
      end
    end
    check_out("win", 1, 0, 0, 1, 4'b1000, 2'd3, 2'd3, 4'hA);

    // Wrong play in round 1.
    start();
    play(4'b0001, 2, 3);
    play(4'b0001, 2, 3);
    play(4'b0001, 2, 3);
    check_out("wrong", 0, 1, 0, 1, 4'b0001, 2'd1, 2'd1, 4'hE);

    // Restart from fim_erro clears counters, then a full win.
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check_out("restart_prep", 0, 0, 0, 0, 4'h0, 2'd0, 2'd0, 4'h1);
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c <= r; c++) begin
        sym = 4'b0001 << c;
        play(sym, 1, 4);
      end
    end
    check_out("restart_win", 1, 0, 0, 1, 4'b1000, 2'd3, 2'd3, 4'hA);

    // Timeout: fim_timeout appears exactly 51 cycles after preparacao.
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("tmo_prep", 32'(db_estado), 32'h1);
    repeat (50) tick();
    chk("tmo_still_waiting", 32'(db_estado), 32'h2);
    tick();
    check_out("tmo", 0, 1, 1, 1, 4'h0, 2'd0, 2'd0, 4'hD);

    // Two keys at once is an error.
    start();
    play(4'b0011, 2, 3);
    check_out("two_keys", 0, 1, 0, 1, 4'b0011, 2'd0, 2'd0, 4'hE);

    // Key held across iniciar is ignored until released.
    chaves = 4'b0001;
    start();
    repeat (8) tick();
    check_out("held_key", 0, 0, 0, 0, 4'h0, 2'd0, 2'd0, 4'h2);
    chaves = 4'b0000;
    tick();
    play(4'b0001, 2, 3);
    check_out("after_release", 0, 0, 0, 0, 4'b0001, 2'd1, 2'd0, 4'h2);

    // Reset mid-round, with keys pressed and iniciar high to test priority.
    play(4'b0001, 2, 3);
    chk("mid_round_cont", 32'(db_contagem), 32'd1);
    reset = 1'b1;
    iniciar = 1'b1;
    chaves = 4'b0010;
    tick();
    check_out("reset_mid", 0, 0, 0, 0, 4'h0, 2'd0, 2'd0, 4'h0);
    reset = 1'b0;
    iniciar = 1'b0;
    chaves = 4'b0000;
    tick();

    // Random games against an abstract model of rounds and positions.
    for (int g = 0; g < 25; g++) begin
      start();
      last = 4'h0;
      fim = 0;
      rf = 0;
      cf = 0;
      for (int r = 0; r < 4 && fim == 0; r++) begin
        for (int c = 0; c <= r && fim == 0; c++) begin
          exp_sym = 4'b0001 << (c % 4);
          if ($urandom_range(0, 24) == 0) begin
            repeat (60) tick();
            fim = 3;
            rf = r;
            cf = c;
          end else begin
            sym = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : exp_sym;
            play(sym, int'($urandom_range(1, 3)), int'($urandom_range(3, 5)));
            last = sym;
            if (sym != exp_sym) begin
              fim = 2;
              rf = r;
              cf = c;
            end else if (r == 3 && c == 3) begin
              fim = 1;
              rf = 3;
              cf = 3;
            end
          end
        end
      end
      tick();
      e_est = (fim == 1) ? 4'hA : (fim == 2) ? 4'hE : 4'hD;
      check_out($sformatf("rand%0d", g), fim == 1, fim >= 2, fim == 3, 1'b1,
                last, 2'(rf), 2'(cf), e_est);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
